// File: rtl/seqdivider.sv
// Sequential restoring divider: one quotient bit per clock.
// A load in IDLE or DONE captures i_a/i_b; WIDTH clocks later out_valid
// rises with out_quot = i_a / i_b and out_rem = i_a % i_b. A zero divisor
// runs the same iterations, giving all-ones quotient, remainder = i_a and
// out_div_zero = 1.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   reset        synchronous active-low reset
//   i_a, i_b     unsigned dividend / divisor, sampled on the accepting edge
//   load         start request, accepted only in IDLE or DONE
//   out_busy     iterations in progress
//   out_valid    out_quot / out_rem hold a finished result
//   out_quot     quotient
//   out_rem      remainder
//   out_div_zero captured divisor was zero (valid with out_valid)
module seqdivider #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             load,
  output logic             out_busy,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_quot,
  output logic [WIDTH-1:0] out_rem,
  output logic             out_div_zero
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [1:0]       next_state;
  logic             accept_c;
  logic             step_c;
  logic             last_c;

  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quot_sr;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH:0]   rem_shift_c;
  logic             ge_c;
  logic [WIDTH-1:0] rem_step_c;
  logic [WIDTH-1:0] quot_step_c;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state and per-cycle control strobes
  always_comb begin
    next_state = state;
    accept_c   = 1'b0;
    step_c     = 1'b0;
    last_c     = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (load) begin
          accept_c   = 1'b1;
          next_state = S_BUSY;
        end
      end
      S_BUSY: begin
        step_c = 1'b1;
        if (cnt == CNT_W'(1)) begin
          last_c     = 1'b1;
          next_state = S_DONE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // One restoring step. The shifted partial remainder is WIDTH+1 bits so the
  // compare sees the bit shifted out; after a subtract the result always fits
  // in WIDTH bits. With a zero divisor every compare succeeds, which yields
  // the all-ones quotient and lets the dividend bits flow into the remainder.
  always_comb begin
    rem_shift_c = {rem, dvd[WIDTH-1]};
    ge_c        = rem_shift_c >= {1'b0, dvs};
    rem_step_c  = ge_c ? WIDTH'(rem_shift_c - {1'b0, dvs})
                       : rem_shift_c[WIDTH-1:0];
    quot_step_c = WIDTH'({quot_sr, ge_c});
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      dvd          <= '0;
      dvs          <= '0;
      rem          <= '0;
      quot_sr      <= '0;
      cnt          <= '0;
      out_busy     <= 1'b0;
      out_valid    <= 1'b0;
      out_quot     <= '0;
      out_rem      <= '0;
      out_div_zero <= 1'b0;
    end else if (accept_c) begin
      dvd          <= i_a;
      dvs          <= i_b;
      rem          <= '0;
      quot_sr      <= '0;
      cnt          <= CNT_W'(WIDTH);
      out_busy     <= 1'b1;
      out_valid    <= 1'b0;
      out_div_zero <= 1'b0;
    end else if (step_c) begin
      dvd     <= dvd << 1;
      rem     <= rem_step_c;
      quot_sr <= quot_step_c;
      cnt     <= cnt - CNT_W'(1);
      if (last_c) begin
        out_quot     <= quot_step_c;
        out_rem      <= rem_step_c;
        out_valid    <= 1'b1;
        out_busy     <= 1'b0;
        out_div_zero <= (dvs == '0);
      end
    end
  end

endmodule

// File: tb/tb_seqdivider.sv
// Bench for seqdivider: table of corner operands, hand-written handshake and
// reset sequences, then random back-to-back operations. Expected results are
// queued when a load is driven and popped when out_valid appears.
module tb_seqdivider;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             load;
  logic             out_busy;
  logic             out_valid;
  logic [WIDTH-1:0] out_quot;
  logic [WIDTH-1:0] out_rem;
  logic             out_div_zero;

  always #5 clk = ~clk;

  seqdivider #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_a          (i_a),
    .i_b          (i_b),
    .load         (load),
    .out_busy     (out_busy),
    .out_valid    (out_valid),
    .out_quot     (out_quot),
    .out_rem      (out_rem),
    .out_div_zero (out_div_zero)
  );

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             dz;
  } vec_t;

  vec_t sb[$];
  vec_t vecs[6];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock; sample/drive 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain / and %, or the divide-by-zero rule.
  function automatic vec_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    vec_t e;
    e.a = a;
    e.b = b;
    if (b == '0) begin
      e.q  = '1;
      e.r  = a;
      e.dz = 1'b1;
    end else begin
      e.q  = a / b;
      e.r  = a % b;
      e.dz = 1'b0;
    end
    return e;
  endfunction

  task automatic do_load(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit push);
    load = 1'b1;
    i_a  = a;
    i_b  = b;
    if (push) sb.push_back(model(a, b));
    tick();
    load = 1'b0;
    chk("accept_busy", 32'(out_busy), 32'd1);
    chk("accept_valid_low", 32'(out_valid), 32'd0);
  endtask

  // Wait for out_valid (bounded), then compare with the scoreboard head.
  task automatic wait_result(input int start_lat);
    int   lat;
    vec_t e;
    lat = start_lat;
    while (!out_valid && lat < 20) begin
      chk("busy_during_op", 32'(out_busy), 32'd1);
      tick();
      lat++;
    end
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty at %0t", $time);
      return;
    end
    e = sb.pop_front();
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL valid_timeout a=%0d b=%0d actual=no_valid required=valid", e.a, e.b);
      return;
    end
    chk("latency", 32'(lat), 32'd8);
    chk("quot", 32'(out_quot), 32'(e.q));
    chk("rem", 32'(out_rem), 32'(e.r));
    chk("div_zero", 32'(out_div_zero), 32'(e.dz));
    chk("busy_done", 32'(out_busy), 32'd0);
    if (!e.dz) begin
      chk("invariant", 32'(int'(out_quot) * int'(e.b) + int'(out_rem)), 32'(e.a));
      chk("rem_lt_b", 32'(out_rem < e.b), 32'd1);
    end
  endtask

  initial begin
    vecs[0] = '{a: 8'd200, b: 8'd7,   q: 8'd28,  r: 8'd4,  dz: 1'b0};
    vecs[1] = '{a: 8'd255, b: 8'd1,   q: 8'd255, r: 8'd0,  dz: 1'b0};
    vecs[2] = '{a: 8'd0,   b: 8'd5,   q: 8'd0,   r: 8'd0,  dz: 1'b0};
    vecs[3] = '{a: 8'd3,   b: 8'd200, q: 8'd0,   r: 8'd3,  dz: 1'b0};
    vecs[4] = '{a: 8'd255, b: 8'd255, q: 8'd1,   r: 8'd0,  dz: 1'b0};
    vecs[5] = '{a: 8'd93,  b: 8'd0,   q: 8'd255, r: 8'd93, dz: 1'b1};

    reset = 1'b0;
    load  = 1'b0;
    i_a   = '0;
    i_b   = '0;
    tick();
    tick();
    chk("rst_busy", 32'(out_busy), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_quot", 32'(out_quot), 32'd0);
    chk("rst_rem", 32'(out_rem), 32'd0);
    chk("rst_div_zero", 32'(out_div_zero), 32'd0);
    reset = 1'b1;

    // Corner operand table, expected values fixed by hand.
    for (int i = 0; i < 6; i++) begin
      vec_t e;
      do_load(vecs[i].a, vecs[i].b, 1'b0);
      sb.push_back(vecs[i]);
      wait_result(0);
      if (i == 0) begin
        e = vecs[0];
        repeat (3) tick();
        chk("done_hold_valid", 32'(out_valid), 32'd1);
        chk("done_hold_quot", 32'(out_quot), 32'(e.q));
        chk("done_hold_rem", 32'(out_rem), 32'(e.r));
      end
    end

    // Load while busy is ignored; the original operands complete on time.
    do_load(8'd100, 8'd9, 1'b1);
    tick();
    tick();
    load = 1'b1;
    i_a  = 8'd50;
    i_b  = 8'd2;
    tick();
    load = 1'b0;
    wait_result(3);

    // Load in DONE: valid drops at the accepting edge, new result 8 later.
    do_load(8'd50, 8'd2, 1'b1);
    wait_result(0);

    // Reset mid-operation, with load also asserted on the reset edge.
    do_load(8'd200, 8'd7, 1'b0);
    tick();
    tick();
    tick();
    reset = 1'b0;
    load  = 1'b1;
    i_a   = 8'd9;
    i_b   = 8'd3;
    tick();
    reset = 1'b1;
    load  = 1'b0;
    chk("midrst_busy", 32'(out_busy), 32'd0);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_quot", 32'(out_quot), 32'd0);
    chk("midrst_rem", 32'(out_rem), 32'd0);
    chk("midrst_div_zero", 32'(out_div_zero), 32'd0);
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("aborted_no_valid", 32'(out_valid), 32'd0);
      chk("aborted_idle", 32'(out_busy), 32'd0);
    end
    do_load(8'd9, 8'd3, 1'b1);
    wait_result(0);

    // Random back-to-back operations, divisor forced to zero now and then.
    for (int n = 0; n < 1000; n++) begin
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      ra = WIDTH'($urandom_range(0, 255));
      rb = (n % 16 == 0) ? '0 : WIDTH'($urandom_range(0, 255));
      do_load(ra, rb, 1'b1);
      wait_result(0);
    end

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seqdivider.md
Name: seqdivider

Overview:
- Sequential restoring divider; the inverse-operation companion to the team's shift-add sequential multiplier.
- Accepts an unsigned dividend/divisor pair on a load strobe and produces quotient and remainder one bit per clock.
- Uses the same load / out_valid handshake style as the multiplier, so both units drop into the same arithmetic datapath and share benches.

Parameters:
WIDTH, 8, operand width in bits; quotient and remainder are each WIDTH bits.

Ports:
clk  input  1  single clock; all state updates on rising edge.
reset  input  1  synchronous, active-low reset; sampled on rising edge of clk, reset=0 resets.
i_a  input  WIDTH  unsigned dividend; sampled only on the accepting edge.
i_b  input  WIDTH  unsigned divisor; sampled only on the accepting edge.
load  input  1  start request; accepted only in IDLE or DONE.
out_busy  output  1  high while iterations are in progress (BUSY state).
out_valid  output  1  high when out_quot/out_rem hold a finished result.
out_quot  output  WIDTH  quotient i_a / i_b.
out_rem  output  WIDTH  remainder i_a % i_b.
out_div_zero  output  1  set with out_valid when the captured divisor was 0.

Behaviour:
- Reset (reset=0 at a rising edge, any state, including mid-operation):
  - state=IDLE.
  - All outputs 0: out_busy, out_valid, out_quot, out_rem, out_div_zero.
  - Internal registers and iteration counter cleared.
  - Any operation in flight is discarded.
- States:
  - IDLE -> BUSY on load=1.
  - BUSY -> DONE after WIDTH iterations.
  - DONE -> BUSY on load=1; otherwise DONE holds.
- Accept edge (load=1 in IDLE/DONE):
  - Capture i_a into the dividend shift register and i_b into the divisor register.
  - Clear the partial remainder (WIDTH+1 bits).
  - Counter=WIDTH.
  - out_valid<=0, out_busy<=1, out_div_zero<=0.
  - out_quot/out_rem are not cleared; they are don't-care while out_valid=0.
- Each BUSY edge performs one restoring step:
  - rem = {rem[WIDTH-1:0], dividend MSB}; dividend shifts left.
  - If rem >= divisor: rem -= divisor and shift 1 into the quotient; otherwise shift 0.
  - Counter decrements.
- Final step (the edge where counter goes 1 -> 0), all in that same edge:
  - out_quot and out_rem written.
  - out_valid<=1, out_busy<=0.
  - out_div_zero<=(divisor==0).
  - state=DONE.
- Latency: load accepted at edge N -> out_valid=1 visible after edge N+WIDTH (8 cycles at default). Fixed; independent of operand values.
- load while BUSY: ignored; the current operation continues unaffected and operands are not recaptured.
- DONE: outputs held stable and out_valid stays 1 until the next accepted load or reset.
  - Load in DONE: out_valid drops at the accepting edge; a new operation starts with no idle cycle (back-to-back).
- Divide by zero:
  - No special path; the algorithm runs the full WIDTH cycles.
  - Result is naturally out_quot = all ones and out_rem = i_a.
  - out_div_zero=1 alongside out_valid.
- Invariant when out_valid=1 and out_div_zero=0: out_quot*i_b + out_rem == i_a and out_rem < i_b.
- reset and load both asserted at the same edge: reset wins.

Test Plan:
1. Reset low 2 cycles, release, load i_a=200, i_b=7 for one cycle -> out_busy high for 8 cycles; out_valid rises exactly 8 edges after accept; out_quot=28, out_rem=4, out_div_zero=0.
2. Corner operands, each run separately:
   - i_a=255, i_b=1 -> q=255, r=0.
   - i_a=0, i_b=5 -> q=0, r=0.
   - i_a=3, i_b=200 -> q=0, r=3.
   - i_a=255, i_b=255 -> q=1, r=0.
3. Divide by zero, i_a=93, i_b=0 -> after 8 cycles out_valid=1, out_quot=255, out_rem=93, out_div_zero=1.
4. Handshake edge cases:
   - Load 100/9; pulse load with i_a=50, i_b=2 at cycle 3 of BUSY -> ignored; result q=11, r=1 at the original latency.
   - Then load 50/2 while in DONE -> out_valid drops at that edge, returns 8 cycles later with q=25, r=0.
5. Load 200/7, drive reset=0 at cycle 4 of BUSY -> next edge all outputs 0, state IDLE; no out_valid ever asserted for that operation; a following load of 9/3 yields q=3, r=0.
6. 1000 random i_a/i_b pairs (including i_b=0), back-to-back loads -> each result matches the reference model (/ and %, or the div-zero rule); latency is always 8.
